// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking barrier gate arbiter.
// Imported by parking_gate_arbiter and gate_rr_arbiter.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OPEN_ENTRY,
        OPEN_EXIT,
        PASSING
    } state_e;

    typedef enum logic {
        DIR_ENTRY,
        DIR_EXIT
    } dir_e;

    localparam int CAPACITY     = 8;
    localparam int PASS_TIMEOUT = 16;

endpackage

// File: rtl/gate_rr_arbiter.sv
// Two-lane arbiter for the barrier gate: bit 0 = entry, bit 1 = exit.
// GATE_ROUND_ROBIN_EN: alternate on contention; otherwise exit has priority.
module gate_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

`ifdef GATE_ROUND_ROBIN_EN
    import parking_pkg::*;

    dir_e ptr_q;
    dir_e ptr_d;

    // Favour the lane not served last; pointer moves on every grant
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (ptr_q == DIR_ENTRY) ? 2'b01 : 2'b10;
        end
        ptr_d = ptr_q;
        if (grant[0]) begin
            ptr_d = DIR_EXIT;
        end else if (grant[1]) begin
            ptr_d = DIR_ENTRY;
        end
    end

    // Pointer register, reset to favour the entry lane
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= DIR_ENTRY;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    // Fixed priority: exit lane always wins
    always_comb begin
        grant = req;
        if (req[1]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/parking_gate_arbiter.sv
// Barrier gate sharing between entry and exit lanes with occupancy tracking.
// Optional round-robin contention handling via GATE_ROUND_ROBIN_EN.
module parking_gate_arbiter #(
    parameter int CAPACITY     = parking_pkg::CAPACITY,
    parameter int CNT_W        = 4,
    parameter int PASS_TIMEOUT = parking_pkg::PASS_TIMEOUT,
    parameter int TMR_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             gate_sensor,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             timeout_alarm
);

    import parking_pkg::*;

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               entry_grant_q, entry_grant_d;
    logic               exit_grant_q, exit_grant_d;
    logic               alarm_q, alarm_d;
    logic [1:0]         arb_req;
    logic [1:0]         arb_gnt;

    // Only idle requests compete; entry is masked while the lot is full
    assign arb_req = (state_q == IDLE) ? {exit_req, entry_req & ~full_q} : 2'b00;

    gate_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (arb_req),
        .grant (arb_gnt)
    );

    assign gate_open     = (state_q != IDLE);
    assign entry_grant   = entry_grant_q & ~rst;
    assign exit_grant    = exit_grant_q & ~rst;
    assign occupancy     = occ_q;
    assign lot_full      = full_q;
    assign lot_empty     = empty_q;
    assign timeout_alarm = alarm_q;

    // Next-state, timer, occupancy and pulse outputs
    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        timer_d       = timer_q;
        occ_d         = occ_q;
        entry_grant_d = 1'b0;
        exit_grant_d  = 1'b0;
        alarm_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (arb_gnt[0]) begin
                    state_d       = OPEN_ENTRY;
                    dir_d         = DIR_ENTRY;
                    entry_grant_d = 1'b1;
                end else if (arb_gnt[1]) begin
                    state_d      = OPEN_EXIT;
                    dir_d        = DIR_EXIT;
                    exit_grant_d = 1'b1;
                end
            end
            OPEN_ENTRY, OPEN_EXIT: begin
                if (gate_sensor) begin
                    state_d = PASSING;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(PASS_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                    alarm_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PASSING: begin
                if (!gate_sensor) begin
                    state_d = IDLE;
                    if (dir_q == DIR_ENTRY) begin
                        occ_d = occ_q + 1'b1;
                    end else if (occ_q != '0) begin
                        occ_d = occ_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        full_d  = (occ_d == CNT_W'(CAPACITY));
        empty_d = (occ_d == '0);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dir_q         <= DIR_ENTRY;
            timer_q       <= '0;
            occ_q         <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            timer_q       <= timer_d;
            occ_q         <= occ_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            entry_grant_q <= entry_grant_d;
            exit_grant_q  <= exit_grant_d;
            alarm_q       <= alarm_d;
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Randomized transaction-level bench for parking_gate_arbiter.
// Honours GATE_ROUND_ROBIN_EN in its arbitration model.
module tb_parking_gate_arbiter;

    localparam int CAP   = 8;
    localparam int CNT_W = 4;
    localparam int PT    = 16;
    localparam int TMR_W = 5;
`ifdef GATE_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             entry_req;
    logic             exit_req;
    logic             gate_sensor;
    logic             entry_grant;
    logic             exit_grant;
    logic             gate_open;
    logic [CNT_W-1:0] occupancy;
    logic             lot_full;
    logic             lot_empty;
    logic             timeout_alarm;

    int checks   = 0;
    int failures = 0;

    int occ_m         = 0;
    bit last_exit_m   = 1'b1;
    bit alarm_pending = 1'b0;

    always #5 clk = ~clk;

    parking_gate_arbiter #(
        .CAPACITY     (CAP),
        .CNT_W        (CNT_W),
        .PASS_TIMEOUT (PT),
        .TMR_W        (TMR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .gate_sensor   (gate_sensor),
        .entry_grant   (entry_grant),
        .exit_grant    (exit_grant),
        .gate_open     (gate_open),
        .occupancy     (occupancy),
        .lot_full      (lot_full),
        .lot_empty     (lot_empty),
        .timeout_alarm (timeout_alarm)
    );

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input bit alarm_exp);
        @(negedge clk);
        check("idle_gate", gate_open, 0);
        check("idle_alarm", timeout_alarm, alarm_exp);
        check("occupancy", occupancy, occ_m);
        check("lot_full", lot_full, occ_m == CAP);
        check("lot_empty", lot_empty, occ_m == 0);
        check("idle_grants", {entry_grant, exit_grant}, 0);
    endtask

    // One arbitration round starting at the beginning of an idle cycle
    task automatic txn(input int entry_pct);
        int win;
        bit ent_ok;
        int d;
        int h;
        if (!entry_req && $urandom_range(99) < entry_pct) entry_req = 1'b1;
        if (!exit_req && $urandom_range(99) < 100 - entry_pct) exit_req = 1'b1;
        ent_ok = entry_req && (occ_m < CAP);
        if (ent_ok && exit_req) win = (RR_EN && last_exit_m) ? 0 : 1;
        else if (ent_ok) win = 0;
        else if (exit_req) win = 1;
        else win = -1;
        gate_sensor = (win < 0) ? 1'($urandom_range(1)) : 1'b0;
        idle_checks(alarm_pending);
        alarm_pending = 1'b0;
        tick();
        if (win < 0) begin
            gate_sensor = 1'b0;
            @(negedge clk);
            check("no_grant", {entry_grant, exit_grant}, 0);
            check("no_open", gate_open, 0);
            tick();
            return;
        end
        last_exit_m = (win == 1);
        if ($urandom_range(5) == 0) begin
            gate_sensor = 1'b0;
            @(negedge clk);
            check("entry_grant", entry_grant, win == 0);
            check("exit_grant", exit_grant, win == 1);
            check("alarm_off", timeout_alarm, 0);
            check("open_first", gate_open, 1);
            for (int i = 2; i <= PT; i++) begin
                tick();
                if (i == 2) begin
                    if (win == 0) entry_req = 1'b0;
                    else exit_req = 1'b0;
                end
                @(negedge clk);
                check("open_wait", gate_open, 1);
                check("grant_pulse", {entry_grant, exit_grant}, 0);
            end
            tick();
            alarm_pending = 1'b1;
            return;
        end
        d = $urandom_range(5);
        h = $urandom_range(1, 4);
        for (int j = 0; j <= d + h; j++) begin
            if (j > 0) tick();
            if (j == 1) begin
                if (win == 0) entry_req = 1'b0;
                else exit_req = 1'b0;
            end
            gate_sensor = (j >= d) && (j < d + h);
            @(negedge clk);
            if (j == 0) begin
                check("entry_grant", entry_grant, win == 0);
                check("exit_grant", exit_grant, win == 1);
                check("alarm_off", timeout_alarm, 0);
            end else begin
                check("grant_pulse", {entry_grant, exit_grant}, 0);
            end
            check("open_pass", gate_open, 1);
        end
        tick();
        if (win == 0) occ_m = occ_m + 1;
        else if (occ_m > 0) occ_m = occ_m - 1;
    endtask

    task automatic model_reset();
        occ_m         = 0;
        last_exit_m   = 1'b1;
        alarm_pending = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        entry_req   = 1'b0;
        exit_req    = 1'b0;
        gate_sensor = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_gate", gate_open, 0);
        check("rst_occ", occupancy, 0);
        check("rst_empty", lot_empty, 1);
        check("rst_full", lot_full, 0);
        check("rst_alarm", timeout_alarm, 0);
        check("rst_grants", {entry_grant, exit_grant}, 0);
        tick();
        rst = 1'b0;
        model_reset();

        for (int n = 0; n < 60; n++) txn(85);
        for (int n = 0; n < 60; n++) txn(15);
        for (int n = 0; n < 40; n++) txn(50);

        // Reset while a vehicle is under the gate
        exit_req  = 1'b0;
        entry_req = 1'b0;
        idle_checks(alarm_pending);
        if (occ_m < CAP) entry_req = 1'b1;
        else exit_req = 1'b1;
        tick();
        gate_sensor = 1'b1;
        tick();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("passing_open", gate_open, 1);
        tick();
        rst         = 1'b0;
        gate_sensor = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_gate", gate_open, 0);
        check("midrst_occ", occupancy, 0);
        check("midrst_empty", lot_empty, 1);
        check("midrst_alarm", timeout_alarm, 0);
        check("midrst_grants", {entry_grant, exit_grant}, 0);
        tick();

        // Reset in the cycle a grant would be shown
        entry_req = 1'b1;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_grant_mask", {entry_grant, exit_grant}, 0);
        tick();
        rst       = 1'b0;
        entry_req = 1'b0;
        model_reset();
        idle_checks(1'b0);
        tick();

        for (int n = 0; n < 60; n++) txn(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
